// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one run/done toggle-handshake memory port
// between NREQ requesters. One memory transaction is outstanding at a time.
// A requester is pending while its run toggle differs from its done toggle.
module bus_arbiter #(
   parameter int NREQ = 2,
   parameter int AW   = 16,
   parameter int DW   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_run,
   input  logic [NREQ-1:0][1:0]     req_cmd,
   input  logic [NREQ-1:0][AW-1:0]  req_addr,
   input  logic [NREQ-1:0][DW-1:0]  req_wr_data,
   output logic [NREQ-1:0][DW-1:0]  req_rd_data,
   output logic [NREQ-1:0]          req_done,
   output logic [AW-1:0]            mem_addr,
   output logic [1:0]               mem_cmd,
   output logic                     mem_run,
   output logic [DW-1:0]            mem_wr_data,
   input  logic [DW-1:0]            mem_rd_data,
   input  logic                     mem_done,
   output logic [2:0]               grant,
   output logic                     busy
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic                      mem_run_q, mem_run_d;
   logic [AW-1:0]             mem_addr_q, mem_addr_d;
   logic [1:0]                mem_cmd_q, mem_cmd_d;
   logic [DW-1:0]             mem_wr_data_q, mem_wr_data_d;
   logic [NREQ-1:0]           req_done_q, req_done_d;
   logic [NREQ-1:0][DW-1:0]   req_rd_data_q, req_rd_data_d;
   logic [2:0]                grant_q, grant_d;
   logic [2:0]                last_q, last_d;
   logic                      busy_q, busy_d;

   logic [NREQ-1:0]           pending_s;
   logic [7:0]                pend8_s;
   logic [3:0]                cand_s;
   logic                      pick_found_s;
   logic [2:0]                pick_s;
   logic [1:0]                sel_cmd_s;
   logic [AW-1:0]             sel_addr_s;
   logic [DW-1:0]             sel_wr_data_s;

   assign pending_s = req_run ^ req_done_q;
   assign pend8_s   = 8'(pending_s);

   // Round-robin choice: first pending index after the last served one, wrapping at NREQ.
   always_comb begin
      pick_found_s = 1'b0;
      pick_s       = 3'd0;
      cand_s       = 4'd0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = {1'b0, last_q} + 4'(k);
         if (cand_s >= 4'(NREQ)) begin
            cand_s = cand_s - 4'(NREQ);
         end else begin
            cand_s = cand_s;
         end
         if (!pick_found_s && pend8_s[cand_s[2:0]]) begin
            pick_found_s = 1'b1;
            pick_s       = cand_s[2:0];
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Request fields of the chosen requester, selected without a variable-width index.
   always_comb begin
      sel_cmd_s     = 2'b00;
      sel_addr_s    = '0;
      sel_wr_data_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_s == 3'(i)) begin
            sel_cmd_s     = req_cmd[i];
            sel_addr_s    = req_addr[i];
            sel_wr_data_s = req_wr_data[i];
         end else begin
            sel_cmd_s     = sel_cmd_s;
         end
      end
   end

   // Next-state and output computation: issue from IDLE, retire on mem_done == mem_run in WAIT.
   always_comb begin
      state_d       = state_q;
      mem_run_d     = mem_run_q;
      mem_addr_d    = mem_addr_q;
      mem_cmd_d     = mem_cmd_q;
      mem_wr_data_d = mem_wr_data_q;
      req_done_d    = req_done_q;
      req_rd_data_d = req_rd_data_q;
      grant_d       = grant_q;
      last_d        = last_q;
      busy_d        = busy_q;
      case (state_q)
         IDLE: begin
            if (pick_found_s) begin
               mem_addr_d    = sel_addr_s;
               mem_cmd_d     = sel_cmd_s;
               mem_wr_data_d = sel_wr_data_s;
               mem_run_d     = ~mem_run_q;
               grant_d       = pick_s;
               busy_d        = 1'b1;
               state_d       = WAIT;
            end else begin
               state_d       = IDLE;
            end
         end
         WAIT: begin
            if (mem_done == mem_run_q) begin
               for (int i = 0; i < NREQ; i++) begin
                  if (grant_q == 3'(i)) begin
                     req_done_d[i] = ~req_done_q[i];
                     // Only reads (cmd bit 0 clear) update the requester's read data.
                     if (!mem_cmd_q[0]) begin
                        req_rd_data_d[i] = mem_rd_data;
                     end else begin
                        req_rd_data_d[i] = req_rd_data_q[i];
                     end
                  end else begin
                     req_done_d[i] = req_done_q[i];
                  end
               end
               last_d  = grant_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any outstanding transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         mem_run_q     <= 1'b0;
         mem_addr_q    <= '0;
         mem_cmd_q     <= 2'b00;
         mem_wr_data_q <= '0;
         req_done_q    <= '0;
         req_rd_data_q <= '0;
         grant_q       <= 3'd0;
         last_q        <= 3'(NREQ - 1);
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_run_q     <= mem_run_d;
         mem_addr_q    <= mem_addr_d;
         mem_cmd_q     <= mem_cmd_d;
         mem_wr_data_q <= mem_wr_data_d;
         req_done_q    <= req_done_d;
         req_rd_data_q <= req_rd_data_d;
         grant_q       <= grant_d;
         last_q        <= last_d;
         busy_q        <= busy_d;
      end
   end

   assign mem_run     = mem_run_q;
   assign mem_addr    = mem_addr_q;
   assign mem_cmd     = mem_cmd_q;
   assign mem_wr_data = mem_wr_data_q;
   assign req_done    = req_done_q;
   assign req_rd_data = req_rd_data_q;
   assign grant       = grant_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a directed vector table, hand-written
// multi-cycle sequences, and a randomized phase scored against a transaction-level model.
module tb_bus_arbiter;
   localparam int NREQ = 2;
   localparam int AW   = 16;
   localparam int DW   = 16;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NREQ-1:0]          req_run;
   logic [NREQ-1:0][1:0]     req_cmd;
   logic [NREQ-1:0][AW-1:0]  req_addr;
   logic [NREQ-1:0][DW-1:0]  req_wr_data;
   logic [NREQ-1:0][DW-1:0]  req_rd_data;
   logic [NREQ-1:0]          req_done;
   logic [AW-1:0]            mem_addr;
   logic [1:0]               mem_cmd;
   logic                     mem_run;
   logic [DW-1:0]            mem_wr_data;
   logic [DW-1:0]            mem_rd_data;
   logic                     mem_done;
   logic [2:0]               grant;
   logic                     busy;

   int errors = 0;
   int checks = 0;
   int mem_delay = 0;
   int mem_cnt;
   logic [15:0] mem_arr [0:255];
   logic exp_run;

   always #5 clk = ~clk;

   bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .req_run(req_run), .req_cmd(req_cmd), .req_addr(req_addr),
      .req_wr_data(req_wr_data), .req_rd_data(req_rd_data), .req_done(req_done),
      .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_run(mem_run),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_done(mem_done),
      .grant(grant), .busy(busy)
   );

   function automatic logic [15:0] init_val(int i);
      logic [7:0] b;
      b = i[7:0];
      if (i == 4) return 16'h1234;
      else return {b, ~b};
   endfunction

   // Memory model: answers mem_delay cycles after seeing run != done; shares the reset.
   always @(posedge clk) begin
      if (reset) begin
         mem_done    <= 1'b0;
         mem_cnt     <= 0;
         mem_rd_data <= 16'h0000;
         for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
      end else if (mem_run != mem_done) begin
         if (mem_cnt >= mem_delay) begin
            mem_cnt  <= 0;
            mem_done <= mem_run;
            if (mem_cmd[0]) mem_arr[mem_addr[7:0]] <= mem_wr_data;
            else mem_rd_data <= mem_arr[mem_addr[7:0]];
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      req_run     = '0;
      req_cmd     = '0;
      req_addr    = '0;
      req_wr_data = '0;
      cyc();
      cyc();
      reset   = 1'b0;
      exp_run = 1'b0;
   endtask

   task automatic toggle_req(input int i, input logic [1:0] c, input logic [15:0] a, input logic [15:0] w);
      req_cmd[i]     = c;
      req_addr[i]    = a;
      req_wr_data[i] = w;
      req_run[i]     = !req_run[i];
   endtask

   task automatic wait_done(input int i, input string name);
      int n = 0;
      while (req_done[i] !== req_run[i] && n < 60) begin
         cyc();
         n++;
      end
      chk(name, req_done[i], req_run[i]);
   endtask

   function automatic int rr_pick(logic [NREQ-1:0] p, int last);
      for (int k = 1; k <= NREQ; k++) begin
         int idx = (last + k) % NREQ;
         if (p[idx]) return idx;
      end
      return 0;
   endfunction

   typedef struct {
      int          req;
      logic [1:0]  cmd;
      logic [15:0] addr;
      logic [15:0] wd;
      int          dly;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vt [6];

   logic [15:0]     mirror [0:255];
   logic [NREQ-1:0] exp_done, pend_prev, done_chg, exp_chg;
   logic [15:0]     exp_rd [NREQ];
   logic            outstanding, out_before, resp_prev, issued, exp_issue;
   int              out_g, model_last, g;
   logic [1:0]      out_cmd;
   logic [15:0]     out_addr, out_wd;

   initial begin
      vt[0] = '{0, 2'b00, 16'h0004, 16'h0000, 0, 16'h1234};
      vt[1] = '{1, 2'b01, 16'h0040, 16'hBEEF, 0, 16'h0000};
      vt[2] = '{0, 2'b00, 16'h0040, 16'h0000, 2, 16'hBEEF};
      vt[3] = '{1, 2'b11, 16'h0010, 16'h00A5, 1, 16'h0000};
      vt[4] = '{1, 2'b10, 16'h0010, 16'h0000, 0, 16'h00A5};
      vt[5] = '{0, 2'b00, 16'h0008, 16'h0000, 3, 16'h08F7};

      do_reset();
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_run", mem_run, 1'b0);
      chk("rst_req_done", req_done, 2'b00);
      chk("rst_grant", grant, 3'd0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_mem_cmd", mem_cmd, 2'b00);
      chk("rst_rd_data", req_rd_data, 32'h0);

      // Single transactions with exact issue and completion latency.
      for (int v = 0; v < 6; v++) begin
         mem_delay = vt[v].dly;
         toggle_req(vt[v].req, vt[v].cmd, vt[v].addr, vt[v].wd);
         cyc();
         exp_run = !exp_run;
         chk("vec_mem_run", mem_run, exp_run);
         chk("vec_mem_addr", mem_addr, vt[v].addr);
         chk("vec_mem_cmd", mem_cmd, vt[v].cmd);
         chk("vec_mem_wd", mem_wr_data, vt[v].wd);
         chk("vec_grant", grant, vt[v].req);
         chk("vec_busy", busy, 1'b1);
         repeat (vt[v].dly + 1) cyc();
         chk("vec_not_yet", req_done[vt[v].req], !req_run[vt[v].req]);
         cyc();
         chk("vec_done", req_done[vt[v].req], req_run[vt[v].req]);
         chk("vec_rd_data", req_rd_data[vt[v].req], vt[v].exp_rd);
         chk("vec_busy_end", busy, 1'b0);
      end

      // Simultaneous requests, each re-raised on completion: strict alternation 0,1,0,1.
      do_reset();
      mem_delay = 0;
      toggle_req(0, 2'b00, 16'h0100, 16'h0000);
      toggle_req(1, 2'b00, 16'h0102, 16'h0000);
      cyc();
      exp_run = !exp_run;
      chk("alt1_grant", grant, 3'd0);
      chk("alt1_run", mem_run, exp_run);
      chk("alt1_addr", mem_addr, 16'h0100);
      wait_done(0, "alt1_done");
      toggle_req(0, 2'b00, 16'h0104, 16'h0000);
      cyc();
      exp_run = !exp_run;
      chk("alt2_grant", grant, 3'd1);
      chk("alt2_run", mem_run, exp_run);
      chk("alt2_addr", mem_addr, 16'h0102);
      wait_done(1, "alt2_done");
      toggle_req(1, 2'b00, 16'h0106, 16'h0000);
      cyc();
      exp_run = !exp_run;
      chk("alt3_grant", grant, 3'd0);
      chk("alt3_addr", mem_addr, 16'h0104);
      wait_done(0, "alt3_done");
      cyc();
      exp_run = !exp_run;
      chk("alt4_grant", grant, 3'd1);
      chk("alt4_addr", mem_addr, 16'h0106);
      wait_done(1, "alt4_done");
      chk("alt4_rd", req_rd_data[1], init_val(6));

      // Slow memory; req1 arrives during WAIT and is issued right after req0 retires.
      mem_delay = 5;
      toggle_req(0, 2'b00, 16'h0004, 16'h0000);
      cyc();
      exp_run = !exp_run;
      chk("slow_grant", grant, 3'd0);
      toggle_req(1, 2'b00, 16'h0040, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("slow_hold_addr", mem_addr, 16'h0004);
         chk("slow_hold_run", mem_run, exp_run);
         chk("slow_hold_busy", busy, 1'b1);
         chk("slow_hold_grant", grant, 3'd0);
      end
      wait_done(0, "slow_done0");
      chk("slow_rd0", req_rd_data[0], 16'h1234);
      mem_delay = 0;
      cyc();
      exp_run = !exp_run;
      chk("slow_next_grant", grant, 3'd1);
      chk("slow_next_run", mem_run, exp_run);
      chk("slow_next_addr", mem_addr, 16'h0040);
      wait_done(1, "slow_done1");
      chk("slow_rd1", req_rd_data[1], 16'h40BF);

      // Back-to-back reads from req0 with req1 idle.
      for (int k = 0; k < 3; k++) begin
         toggle_req(0, 2'b00, 16'(16'h0020 + 2 * k), 16'h0000);
         cyc();
         exp_run = !exp_run;
         chk("b2b_run", mem_run, exp_run);
         chk("b2b_grant", grant, 3'd0);
         wait_done(0, "b2b_done");
         chk("b2b_rd", req_rd_data[0], init_val(32 + 2 * k));
      end

      // Reset while a transaction is outstanding.
      do_reset();
      mem_delay = 20;
      toggle_req(0, 2'b00, 16'h0004, 16'h0000);
      cyc();
      chk("rstw_busy_before", busy, 1'b1);
      cyc();
      cyc();
      reset   = 1'b1;
      req_run = '0;
      cyc();
      reset   = 1'b0;
      exp_run = 1'b0;
      chk("rstw_busy", busy, 1'b0);
      chk("rstw_mem_run", mem_run, 1'b0);
      chk("rstw_req_done", req_done, 2'b00);
      chk("rstw_grant", grant, 3'd0);
      repeat (5) cyc();
      chk("rstw_no_toggle", req_done, 2'b00);
      mem_delay = 0;
      toggle_req(0, 2'b00, 16'h0008, 16'h0000);
      cyc();
      chk("rstw_new_run", mem_run, 1'b1);
      chk("rstw_new_grant", grant, 3'd0);
      wait_done(0, "rstw_new_done");
      chk("rstw_new_rd", req_rd_data[0], 16'h08F7);

      // Randomized traffic scored by a transaction-level model.
      do_reset();
      for (int i = 0; i < 256; i++) mirror[i] = init_val(i);
      exp_done    = '0;
      outstanding = 1'b0;
      out_g       = 0;
      model_last  = NREQ - 1;
      out_cmd     = 2'b00;
      out_addr    = 16'h0000;
      out_wd      = 16'h0000;
      for (int i = 0; i < NREQ; i++) exp_rd[i] = 16'h0000;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_run[i] == exp_done[i] && $urandom_range(0, 2) == 0) begin
               toggle_req(i, 2'($urandom_range(0, 3)), {8'h00, 8'($urandom_range(0, 15) * 2)},
                          16'($urandom));
            end
         end
         pend_prev = req_run ^ exp_done;
         resp_prev = outstanding && (mem_done === exp_run);
         if (!outstanding) mem_delay = $urandom_range(0, 3);
         cyc();
         out_before = outstanding;
         done_chg   = req_done ^ exp_done;
         exp_chg    = resp_prev ? (2'b01 << out_g) : 2'b00;
         chk("rnd_done", done_chg, exp_chg);
         if (resp_prev) begin
            if (!out_cmd[0]) begin
               chk("rnd_rd", req_rd_data[out_g], mirror[out_addr[7:0]]);
               exp_rd[out_g] = mirror[out_addr[7:0]];
            end else begin
               mirror[out_addr[7:0]] = out_wd;
               chk("rnd_wr_keep", req_rd_data[out_g], exp_rd[out_g]);
            end
            exp_done[out_g] = !exp_done[out_g];
            model_last      = out_g;
            outstanding     = 1'b0;
         end
         issued    = (mem_run !== exp_run);
         exp_issue = !out_before && (pend_prev != '0);
         chk("rnd_issue", issued, exp_issue);
         if (issued && exp_issue) begin
            g = rr_pick(pend_prev, model_last);
            chk("rnd_grant", grant, g);
            chk("rnd_addr", mem_addr, req_addr[g]);
            chk("rnd_cmd", mem_cmd, req_cmd[g]);
            chk("rnd_wd", mem_wr_data, req_wr_data[g]);
            out_cmd     = req_cmd[g];
            out_addr    = req_addr[g];
            out_wd      = req_wr_data[g];
            out_g       = g;
            outstanding = 1'b1;
            exp_run     = !exp_run;
         end
         chk("rnd_busy", busy, outstanding);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
